// File: rtl/my_pkg.sv
// Shared decoder types: instruction format, operation index and execute-unit
// select, the packed decode result, RV32I opcode constants and the NOP word.
package my_pkg;

    typedef enum logic [2:0] {
        R_type = 3'd0,
        I_type = 3'd1,
        S_type = 3'd2,
        B_type = 3'd3,
        U_type = 3'd4,
        J_type = 3'd5,
        N_type = 3'd6
    } fmts;

    typedef enum logic [2:0] {
        OP0 = 3'd0,
        OP1 = 3'd1,
        OP2 = 3'd2,
        OP3 = 3'd3,
        OP4 = 3'd4,
        OP5 = 3'd5,
        OP6 = 3'd6,
        OP7 = 3'd7
    } instruction_type;

    typedef enum logic [2:0] {
        bypass  = 3'd0,
        adder   = 3'd1,
        branch  = 3'd2,
        memory  = 3'd3,
        logical = 3'd4,
        shifter = 3'd5
    } xu;

    typedef struct packed {
        fmts             f;
        xu               x;
        instruction_type i;
    } dec_t;

    // addi x0, x0, 0 -- the canonical RV32I no-operation
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Bundle a format / unit / operation triple into one decode result
    function automatic dec_t mk_dec(input fmts f, input xu x, input instruction_type i);
        dec_t d;
        d.f = f;
        d.x = x;
        d.i = i;
        return d;
    endfunction

endpackage

// File: rtl/decode_logic.sv
// Purely combinational RV32I decode: opcode/funct3/funct7 to format,
// execute unit and operation index. Anything not recognised is the NOP triple.
module decode_logic
    import my_pkg::*;
(
    input  logic [31:0]     i_instruction,
    output fmts             o_fmt,
    output instruction_type o_i,
    output xu               o_xu
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_unused;
    dec_t       w_dec;

    assign w_opcode = i_instruction[6:0];
    assign w_funct3 = i_instruction[14:12];
    assign w_funct7 = i_instruction[31:25];
    // register and immediate fields play no part in classification
    assign w_unused = ^{i_instruction[24:15], i_instruction[11:7]};

    // Classify the word; every leaf that is not a listed instruction keeps the NOP default
    always_comb begin
        w_dec = mk_dec(N_type, bypass, OP0);
        case (w_opcode)
            OPC_LUI:   w_dec = mk_dec(U_type, bypass, OP0);
            OPC_AUIPC: w_dec = mk_dec(U_type, adder, OP0);
            OPC_JAL:   w_dec = mk_dec(J_type, branch, OP0);
            OPC_JALR: begin
                if (w_funct3 == 3'b000) w_dec = mk_dec(I_type, branch, OP1);
            end
            OPC_BRANCH: begin
                case (w_funct3)
                    3'b000:  w_dec = mk_dec(B_type, branch, OP2);
                    3'b001:  w_dec = mk_dec(B_type, branch, OP3);
                    3'b100:  w_dec = mk_dec(B_type, branch, OP4);
                    3'b101:  w_dec = mk_dec(B_type, branch, OP5);
                    3'b110:  w_dec = mk_dec(B_type, branch, OP6);
                    3'b111:  w_dec = mk_dec(B_type, branch, OP7);
                    default: ;
                endcase
            end
            OPC_LOAD: begin
                case (w_funct3)
                    3'b000:  w_dec = mk_dec(I_type, memory, OP0);
                    3'b100:  w_dec = mk_dec(I_type, memory, OP1);
                    3'b001:  w_dec = mk_dec(I_type, memory, OP2);
                    3'b101:  w_dec = mk_dec(I_type, memory, OP3);
                    3'b010:  w_dec = mk_dec(I_type, memory, OP4);
                    default: ;
                endcase
            end
            OPC_STORE: begin
                case (w_funct3)
                    3'b000:  w_dec = mk_dec(S_type, memory, OP5);
                    3'b001:  w_dec = mk_dec(S_type, memory, OP6);
                    3'b010:  w_dec = mk_dec(S_type, memory, OP7);
                    default: ;
                endcase
            end
            OPC_OP: begin
                if (w_funct7 == F7_BASE) begin
                    case (w_funct3)
                        3'b000:  w_dec = mk_dec(R_type, adder, OP0);
                        3'b010:  w_dec = mk_dec(R_type, adder, OP2);
                        3'b011:  w_dec = mk_dec(R_type, adder, OP3);
                        3'b111:  w_dec = mk_dec(R_type, logical, OP0);
                        3'b110:  w_dec = mk_dec(R_type, logical, OP1);
                        3'b100:  w_dec = mk_dec(R_type, logical, OP2);
                        3'b001:  w_dec = mk_dec(R_type, shifter, OP0);
                        3'b101:  w_dec = mk_dec(R_type, shifter, OP1);
                        default: ;
                    endcase
                end else if (w_funct7 == F7_ALT) begin
                    case (w_funct3)
                        3'b000:  w_dec = mk_dec(R_type, adder, OP1);
                        3'b101:  w_dec = mk_dec(R_type, shifter, OP2);
                        default: ;
                    endcase
                end
            end
            OPC_OPIMM: begin
                case (w_funct3)
                    3'b000:  w_dec = mk_dec(I_type, adder, OP0);
                    3'b010:  w_dec = mk_dec(I_type, adder, OP2);
                    3'b011:  w_dec = mk_dec(I_type, adder, OP3);
                    3'b111:  w_dec = mk_dec(I_type, logical, OP0);
                    3'b110:  w_dec = mk_dec(I_type, logical, OP1);
                    3'b100:  w_dec = mk_dec(I_type, logical, OP2);
                    3'b001: begin
                        if (w_funct7 == F7_BASE) w_dec = mk_dec(I_type, shifter, OP0);
                    end
                    3'b101: begin
                        if (w_funct7 == F7_BASE)     w_dec = mk_dec(I_type, shifter, OP1);
                        else if (w_funct7 == F7_ALT) w_dec = mk_dec(I_type, shifter, OP2);
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign o_fmt = w_dec.f;
    assign o_i   = w_dec.i;
    assign o_xu  = w_dec.x;

endmodule

// File: rtl/decoder.sv
// Decode stage: registers the decoded fetch word, with a one-entry skid buffer
// that absorbs a word arriving while operand fetch stalls, and a squash path.
module decoder
    import my_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    input  logic [31:0]     instruction_in,
    input  logic [31:0]     NPC_in,
    input  logic [3:0]      tag_in,
    input  logic            bubble,
    input  logic            jump,
    output logic            stall_out,
    output logic [31:0]     instruction_out,
    output logic [31:0]     NPC_out,
    output logic [3:0]      tag_out,
    output fmts             fmt,
    output instruction_type i_out,
    output xu               xu_sel
);

    logic            r_skid_valid;
    logic [31:0]     r_skid_instr;
    logic [31:0]     r_skid_npc;
    logic [3:0]      r_skid_tag;

    logic [31:0]     w_src_instr;
    logic [31:0]     w_src_npc;
    logic [3:0]      w_src_tag;
    logic            w_capture;
    fmts             w_fmt;
    instruction_type w_i;
    xu               w_xu;

    // A held word always takes precedence over the fetch port
    assign w_src_instr = r_skid_valid ? r_skid_instr : instruction_in;
    assign w_src_npc   = r_skid_valid ? r_skid_npc   : NPC_in;
    assign w_src_tag   = r_skid_valid ? r_skid_tag   : tag_in;

    // Only an empty skid may capture; a second word during a stall is dropped
    assign w_capture = ~jump & ~bubble & valid_in & ~r_skid_valid;

    assign stall_out = ~bubble | r_skid_valid;

    decode_logic u_decode_logic (
        .i_instruction (w_src_instr),
        .o_fmt         (w_fmt),
        .o_i           (w_i),
        .o_xu          (w_xu)
    );

    // Skid payload: meaningful only while r_skid_valid is set, so no reset needed
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_skid_instr <= instruction_in;
            r_skid_npc   <= NPC_in;
            r_skid_tag   <= tag_in;
        end
    end

    // Output register and skid occupancy: squash > stall-hold > skid drain > accept > idle NOP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instruction_out <= NOP_INSTR;
            NPC_out         <= '0;
            tag_out         <= '0;
            fmt             <= N_type;
            i_out           <= OP0;
            xu_sel          <= bypass;
            r_skid_valid    <= 1'b0;
        end else if (jump) begin
            instruction_out <= NOP_INSTR;
            NPC_out         <= '0;
            tag_out         <= '0;
            fmt             <= N_type;
            i_out           <= OP0;
            xu_sel          <= bypass;
            r_skid_valid    <= 1'b0;
        end else if (!bubble) begin
            if (w_capture) r_skid_valid <= 1'b1;
        end else if (r_skid_valid || valid_in) begin
            instruction_out <= w_src_instr;
            NPC_out         <= w_src_npc;
            tag_out         <= w_src_tag;
            fmt             <= w_fmt;
            i_out           <= w_i;
            xu_sel          <= w_xu;
            r_skid_valid    <= 1'b0;
        end else begin
            instruction_out <= NOP_INSTR;
            NPC_out         <= '0;
            tag_out         <= '0;
            fmt             <= N_type;
            i_out           <= OP0;
            xu_sel          <= bypass;
        end
    end

endmodule

// File: tb/tb_decoder.sv
// Bench for the decode stage: directed scenarios followed by randomized traffic,
// all checked against a mnemonic-table reference model.
module tb_decoder;
    import my_pkg::*;

    typedef struct packed {
        fmts             f;
        xu               x;
        instruction_type op;
    } trip_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            valid_in;
    logic [31:0]     instruction_in;
    logic [31:0]     NPC_in;
    logic [3:0]      tag_in;
    logic            bubble;
    logic            jump;
    logic            stall_out;
    logic [31:0]     instruction_out;
    logic [31:0]     NPC_out;
    logic [3:0]      tag_out;
    fmts             fmt;
    instruction_type i_out;
    xu               xu_sel;

    decoder dut (
        .clk             (clk),
        .reset           (reset),
        .valid_in        (valid_in),
        .instruction_in  (instruction_in),
        .NPC_in          (NPC_in),
        .tag_in          (tag_in),
        .bubble          (bubble),
        .jump            (jump),
        .stall_out       (stall_out),
        .instruction_out (instruction_out),
        .NPC_out         (NPC_out),
        .tag_out         (tag_out),
        .fmt             (fmt),
        .i_out           (i_out),
        .xu_sel          (xu_sel)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    trip_t tbl[string];

    // reference state: visible outputs and the skid entry
    logic [31:0] m_instr, m_npc, m_sk_instr, m_sk_npc;
    logic [3:0]  m_tag, m_sk_tag;
    trip_t       m_t;
    logic        m_skv;

    logic [6:0] opcs [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                             7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011};

    task automatic put(input string m, input fmts f, input xu x, input instruction_type o);
        trip_t t;
        t.f = f; t.x = x; t.op = o;
        tbl[m] = t;
    endtask

    task automatic build_table();
        put("LUI", U_type, bypass, OP0);   put("AUIPC", U_type, adder, OP0);
        put("JAL", J_type, branch, OP0);   put("JALR", I_type, branch, OP1);
        put("BEQ", B_type, branch, OP2);   put("BNE", B_type, branch, OP3);
        put("BLT", B_type, branch, OP4);   put("BGE", B_type, branch, OP5);
        put("BLTU", B_type, branch, OP6);  put("BGEU", B_type, branch, OP7);
        put("LB", I_type, memory, OP0);    put("LBU", I_type, memory, OP1);
        put("LH", I_type, memory, OP2);    put("LHU", I_type, memory, OP3);
        put("LW", I_type, memory, OP4);    put("SB", S_type, memory, OP5);
        put("SH", S_type, memory, OP6);    put("SW", S_type, memory, OP7);
        put("ADD", R_type, adder, OP0);    put("SUB", R_type, adder, OP1);
        put("SLT", R_type, adder, OP2);    put("SLTU", R_type, adder, OP3);
        put("AND", R_type, logical, OP0);  put("OR", R_type, logical, OP1);
        put("XOR", R_type, logical, OP2);  put("SLL", R_type, shifter, OP0);
        put("SRL", R_type, shifter, OP1);  put("SRA", R_type, shifter, OP2);
        put("ADDI", I_type, adder, OP0);   put("SLTI", I_type, adder, OP2);
        put("SLTIU", I_type, adder, OP3);  put("ANDI", I_type, logical, OP0);
        put("ORI", I_type, logical, OP1);  put("XORI", I_type, logical, OP2);
        put("SLLI", I_type, shifter, OP0); put("SRLI", I_type, shifter, OP1);
        put("SRAI", I_type, shifter, OP2);
    endtask

    // Name the RV32I instruction encoded in w, or "ILL"
    function automatic string mnem(input logic [31:0] w);
        logic [2:0] f3;
        logic [6:0] f7;
        string s;
        f3 = w[14:12];
        f7 = w[31:25];
        s = "ILL";
        case (w[6:0])
            7'b0110111: s = "LUI";
            7'b0010111: s = "AUIPC";
            7'b1101111: s = "JAL";
            7'b1100111: if (f3 == 3'd0) s = "JALR";
            7'b1100011: case (f3)
                3'd0: s = "BEQ";  3'd1: s = "BNE";  3'd4: s = "BLT";
                3'd5: s = "BGE";  3'd6: s = "BLTU"; 3'd7: s = "BGEU";
                default: s = "ILL";
            endcase
            7'b0000011: case (f3)
                3'd0: s = "LB"; 3'd1: s = "LH"; 3'd2: s = "LW"; 3'd4: s = "LBU"; 3'd5: s = "LHU";
                default: s = "ILL";
            endcase
            7'b0100011: case (f3)
                3'd0: s = "SB"; 3'd1: s = "SH"; 3'd2: s = "SW";
                default: s = "ILL";
            endcase
            7'b0110011: begin
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0: s = "ADD"; 3'd1: s = "SLL"; 3'd2: s = "SLT"; 3'd3: s = "SLTU";
                        3'd4: s = "XOR"; 3'd5: s = "SRL"; 3'd6: s = "OR";  3'd7: s = "AND";
                        default: s = "ILL";
                    endcase
                end else if (f7 == 7'h20) begin
                    if (f3 == 3'd0) s = "SUB";
                    else if (f3 == 3'd5) s = "SRA";
                end
            end
            7'b0010011: case (f3)
                3'd0: s = "ADDI"; 3'd2: s = "SLTI"; 3'd3: s = "SLTIU";
                3'd4: s = "XORI"; 3'd6: s = "ORI";  3'd7: s = "ANDI";
                3'd1: if (f7 == 7'h00) s = "SLLI";
                3'd5: begin
                    if (f7 == 7'h00) s = "SRLI";
                    else if (f7 == 7'h20) s = "SRAI";
                end
                default: s = "ILL";
            endcase
            default: s = "ILL";
        endcase
        return s;
    endfunction

    function automatic trip_t ref_dec(input logic [31:0] w);
        trip_t t;
        string m;
        m = mnem(w);
        t.f = N_type; t.x = bypass; t.op = OP0;
        if (tbl.exists(m)) t = tbl[m];
        return t;
    endfunction

    task automatic model_nop();
        m_instr = NOP_INSTR;
        m_npc   = '0;
        m_tag   = '0;
        m_t.f = N_type; m_t.x = bypass; m_t.op = OP0;
    endtask

    // Advance the reference by one clock edge using the inputs now applied
    task automatic model_edge();
        if (jump) begin
            model_nop();
            m_skv = 1'b0;
        end else if (!bubble) begin
            if (valid_in && !m_skv) begin
                m_skv = 1'b1;
                m_sk_instr = instruction_in; m_sk_npc = NPC_in; m_sk_tag = tag_in;
            end
        end else if (m_skv) begin
            m_instr = m_sk_instr; m_npc = m_sk_npc; m_tag = m_sk_tag;
            m_t = ref_dec(m_sk_instr);
            m_skv = 1'b0;
        end else if (valid_in) begin
            m_instr = instruction_in; m_npc = NPC_in; m_tag = tag_in;
            m_t = ref_dec(instruction_in);
        end else begin
            model_nop();
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_instr"}, instruction_out, m_instr);
        chk({tag, "_npc"},   NPC_out,         m_npc);
        chk({tag, "_tag"},   {28'd0, tag_out}, {28'd0, m_tag});
        chk({tag, "_fmt"},   {29'd0, fmt},    {29'd0, m_t.f});
        chk({tag, "_xu"},    {29'd0, xu_sel}, {29'd0, m_t.x});
        chk({tag, "_op"},    {29'd0, i_out},  {29'd0, m_t.op});
    endtask

    task automatic chk_trip(input string tag, input fmts f, input xu x, input instruction_type o);
        chk({tag, "_fmt_c"}, {29'd0, fmt},    {29'd0, f});
        chk({tag, "_xu_c"},  {29'd0, xu_sel}, {29'd0, x});
        chk({tag, "_op_c"},  {29'd0, i_out},  {29'd0, o});
    endtask

    // One clock: apply inputs at the falling edge, check stall_out, then outputs after the rise
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] npc,
                         input logic [3:0] tg, input logic bub, input logic jmp, input string tag);
        valid_in = v; instruction_in = ins; NPC_in = npc; tag_in = tg;
        bubble = bub; jump = jmp;
        #1;
        chk({tag, "_stall"}, {31'd0, stall_out}, {31'd0, (~bub) | m_skv});
        @(posedge clk);
        model_edge();
        #1;
        check_outs(tag);
        @(negedge clk);
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        int r;
        w = $urandom;
        r = $urandom_range(0, 99);
        if (r < 85) w[6:0] = opcs[$urandom_range(0, 8)];
        r = $urandom_range(0, 9);
        if (r < 5) w[31:25] = 7'h00;
        else if (r < 8) w[31:25] = 7'h20;
        return w;
    endfunction

    initial begin
        build_table();
        m_skv = 1'b0;
        m_sk_instr = '0; m_sk_npc = '0; m_sk_tag = '0;
        model_nop();

        reset = 1'b1; valid_in = 1'b0; instruction_in = '0; NPC_in = '0; tag_in = '0;
        bubble = 1'b1; jump = 1'b0;

        // reset acts without a clock edge
        #3 reset = 1'b0;
        #1;
        check_outs("reset");
        chk_trip("reset", N_type, bypass, OP0);
        chk("reset_stall", {31'd0, stall_out}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // plain decode of add x5,x6,x10
        cycle(1'b1, 32'h00A3_02B3, 32'h0000_1004, 4'h9, 1'b1, 1'b0, "add");
        chk_trip("add", R_type, adder, OP0);
        chk("add_tag_c", {28'd0, tag_out}, 32'd9);

        // stall two cycles, then lw arrives into the skid
        cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, "hold1");
        cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, "hold2");
        cycle(1'b1, 32'h0042_A303, 32'h0000_1008, 4'h3, 1'b0, 1'b0, "skidin");
        chk_trip("skidin_held", R_type, adder, OP0);
        cycle(1'b1, 32'h0000_0033, 32'h0000_100C, 4'h4, 1'b0, 1'b0, "skidovr");
        cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, "drain");
        chk_trip("drain", I_type, memory, OP4);
        chk("drain_tag_c", {28'd0, tag_out}, 32'd3);
        cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, "idle");

        // squash with a full skid
        cycle(1'b1, 32'h0062_8463, 32'h0000_2000, 4'h5, 1'b0, 1'b0, "sqfill");
        cycle(1'b1, 32'h0000_0013, 32'h0000_2004, 4'h6, 1'b0, 1'b1, "squash");
        chk_trip("squash", N_type, bypass, OP0);
        cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, "postsq");

        // illegal word
        cycle(1'b1, 32'hFFFF_FFFF, 32'h0000_3000, 4'h7, 1'b1, 1'b0, "illegal");
        chk_trip("illegal", N_type, bypass, OP0);

        // reset in the middle of a stall with a stored word
        cycle(1'b1, 32'h0000_A2B7, 32'h0000_4000, 4'hA, 1'b0, 1'b0, "rsfill");
        #2 reset = 1'b0;
        #1;
        model_nop();
        m_skv = 1'b0;
        check_outs("rstmid");
        bubble = 1'b1;
        #1;
        chk("rstmid_stall", {31'd0, stall_out}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, "noreplay");
        chk("noreplay_c", instruction_out, NOP_INSTR);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 3) != 0), gen_instr(), $urandom, 4'($urandom),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/decoder.md
DECODER -- requirements
Module: decoder

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 The port list SHALL be exactly as follows, clock and reset first:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- valid_in  in  1  fetch word valid
- instruction_in  in  32  RV32I object code from instruction memory
- NPC_in  in  32  next PC of the fetched word
- tag_in  in  4  instruction tag
- bubble  in  1  operandFetch hazard indicator, 0 = stall
- jump  in  1  taken branch/jump, squash
- stall_out  out  1  fetch-hold request, 1 = hold PC
- instruction_out  out  32  registered object code
- NPC_out  out  32  registered NPC
- tag_out  out  4  registered tag
- fmt  out  fmts  instruction format
- i_out  out  instruction_type  operation OP0..OP7
- xu_sel  out  xu  execute unit select

Function
REQ-003 Decode SHALL be combinational from instruction_in (or the skid entry) and registered into the outputs; latency is 1 cycle from an accepted valid_in to the outputs.
REQ-004 Decode mapping SHALL be:
- LUI: U_type, bypass, OP0; AUIPC: U_type, adder, OP0
- JAL: J_type, branch, OP0; JALR: I_type, branch, OP1
- BEQ/BNE/BLT/BGE/BLTU/BGEU: B_type, branch, OP2..OP7
- LB/LBU/LH/LHU/LW: I_type, memory, OP0..OP4; SB/SH/SW: S_type, memory, OP5..OP7
- ADD(I)/SUB/SLT(I)/SLTU(I): R/I_type, adder, OP0/OP1/OP2/OP3
- AND/OR/XOR(I): logical, OP0..OP2; SLL/SRL/SRA(I): shifter, OP0..OP2
REQ-005 Any unlisted opcode/funct3/funct7 combination SHALL decode to the NOP triple: N_type, bypass, OP0.
REQ-006 A NOP output SHALL drive instruction_out=0x00000013, NPC_out=0, tag_out=0, and the NOP triple.
REQ-007 Accept occurs when valid_in=1, bubble=1, skid empty and jump=0: outputs load the decoded instruction_in.
REQ-008 When bubble=0, all outputs SHALL hold their values.
REQ-009 When bubble=0 and valid_in=1 with the skid empty, the word SHALL be captured into a one-entry skid buffer (instruction, NPC, tag); skid_valid becomes 1.
REQ-010 When bubble=1 and skid_valid=1, outputs SHALL load the decoded skid entry and skid_valid SHALL clear; valid_in is ignored that cycle.
REQ-011 stall_out SHALL equal (~bubble) | skid_valid, combinationally.
REQ-012 valid_in=1 while skid_valid=1 and bubble=0 is a protocol violation; the skid SHALL NOT be overwritten.
REQ-013 When bubble=1, valid_in=0, skid empty and jump=0, outputs SHALL load NOP.
REQ-014 jump=1 SHALL, at the next edge, load NOP into the outputs and clear skid_valid regardless of bubble/valid_in; it has priority over REQ-007..REQ-013.

Reset
REQ-015 reset=0 SHALL immediately force all outputs to the NOP values of REQ-006 and clear skid_valid.
REQ-016 Reset asserted mid-stall SHALL discard the skid content; after release the first edge behaves as an empty-skid cycle.

Structure
REQ-017 The enums fmts (including N_type), instruction_type and xu SHALL reside in my_pkg alongside the existing definitions; the NOP instruction constant 0x00000013 SHALL also go in my_pkg.
REQ-018 The combinational decode SHALL be a sub-module decode_logic (instruction in; fmt, i, xu out), instantiated once and fed by a mux of skid entry vs instruction_in.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset: reset=0 -> instruction_out=0x13, xu_sel=bypass, i_out=OP0, fmt=N_type, skid_valid=0.
- Decode: valid_in=1, bubble=1, instruction_in=0x00A302B3 (add x5,x6,x10) -> next cycle R_type, adder, OP0, tag_out=tag_in.
- Skid: bubble=0 for 2 cycles, then valid_in with 0x0042A303 (lw) -> outputs held, stall_out=1; on bubble=1 outputs show I_type, memory, OP4 and stall_out drops one cycle later.
- Squash: skid full, jump=1 -> next cycle NOP outputs, skid_valid=0, stall_out=bubble-inverted only.
- Illegal: instruction_in=0xFFFFFFFF -> NOP triple.
- Reset mid-stall: skid full, reset pulse -> NOP outputs, skid empty, no replay of the stored word.
